// File: rtl/bcd_updown_counter.sv
// ----------------------------------------------------------------------------
// bcd_updown_counter
//   Parametrised multi-digit BCD up/down counter with enable, synchronous
//   load and a programmable modulus (counts 0..MAX_VAL). It feeds 7-segment
//   drivers and timer datapaths, and cascades through tc (combinational) and
//   wrap (registered pulse).
//
// Parameters
//   DIGITS   number of BCD digits (1..8); q is 4*DIGITS bits wide
//   MAX_VAL  terminal count as a decimal integer (< 10**DIGITS)
//   RST_VAL  decimal value used on reset and on an illegal load (<= MAX_VAL)
//
// Ports
//   clk       in   rising-edge clock
//   rst_n     in   asynchronous active-low reset
//   en        in   count enable, one step per clock while high
//   up_dn     in   1 = count up, 0 = count down
//   load      in   synchronous load strobe; takes priority over en
//   load_val  in   BCD value to load, digit k at [4k+3:4k]
//   q         out  registered BCD count
//   tc        out  terminal count: en & ((up_dn & q==MAX) | (~up_dn & q==0))
//   wrap      out  one-cycle pulse in the cycle after a wrap
//   err       out  one-cycle pulse in the cycle after an illegal load
//
// Build option
//   BCD_CNT_SAT_EN  when defined the counter saturates at the boundaries
//                   instead of wrapping, and wrap never asserts.
// ----------------------------------------------------------------------------
module bcd_updown_counter #(
    parameter int DIGITS  = 2,
    parameter int MAX_VAL = 59,
    parameter int RST_VAL = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                en,
    input  logic                up_dn,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    output logic [4*DIGITS-1:0] q,
    output logic                tc,
    output logic                wrap,
    output logic                err
);

    localparam int W = 4 * DIGITS;

    // Decimal integer to packed BCD, evaluated at elaboration only.
    function automatic logic [W-1:0] to_bcd(input int value);
        logic [W-1:0] r;
        int           v;
        r = '0;
        v = value;
        for (int k = 0; k < DIGITS; k++) begin
            r[4*k +: 4] = 4'(v % 10);
            v           = v / 10;
        end
        return r;
    endfunction

    localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_VAL);
    localparam logic [W-1:0] RST_BCD = to_bcd(RST_VAL);

    generate
        if (DIGITS < 1 || DIGITS > 8) begin : g_bad_digits
            $error("bcd_updown_counter: DIGITS must be in 1..8");
        end
        else if (MAX_VAL < 0 || MAX_VAL >= 10 ** DIGITS) begin : g_bad_max
            $error("bcd_updown_counter: MAX_VAL must be in 0..10**DIGITS-1");
        end
        else if (RST_VAL < 0 || RST_VAL > MAX_VAL) begin : g_bad_rst
            $error("bcd_updown_counter: RST_VAL must be in 0..MAX_VAL");
        end
    endgenerate

    logic [W-1:0] inc_val;
    logic [W-1:0] dec_val;
    logic         inc_carry;
    logic         dec_borrow;
    logic         digits_ok;
    logic         load_legal;
    logic         at_max;
    logic         at_zero;
    logic [W-1:0] q_next;
    logic         wrap_next;
    logic         err_next;

    assign at_max  = (q == MAX_BCD);
    assign at_zero = (q == '0);

    // Digit-wise increment: the carry ripples through all digits in one cycle.
    always_comb begin
        inc_val   = q;
        inc_carry = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (inc_carry) begin
                if (q[4*k +: 4] >= 4'd9) begin
                    inc_val[4*k +: 4] = 4'd0;
                end
                else begin
                    inc_val[4*k +: 4] = q[4*k +: 4] + 4'd1;
                    inc_carry         = 1'b0;
                end
            end
        end
    end

    // Digit-wise decrement: a zero digit becomes 9 and borrows from the next.
    always_comb begin
        dec_val    = q;
        dec_borrow = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (dec_borrow) begin
                if (q[4*k +: 4] == 4'd0) begin
                    dec_val[4*k +: 4] = 4'd9;
                end
                else begin
                    dec_val[4*k +: 4] = q[4*k +: 4] - 4'd1;
                    dec_borrow        = 1'b0;
                end
            end
        end
    end

    // With every digit <= 9, an unsigned compare of the packed BCD words
    // orders them the same way as their decimal values.
    always_comb begin
        digits_ok = 1'b1;
        for (int k = 0; k < DIGITS; k++) begin
            if (load_val[4*k +: 4] > 4'd9) begin
                digits_ok = 1'b0;
            end
        end
    end

    assign load_legal = digits_ok && (load_val <= MAX_BCD);

    always_comb begin
        q_next    = q;
        wrap_next = 1'b0;
        err_next  = 1'b0;
        if (load) begin
            if (load_legal) begin
                q_next = load_val;
            end
            else begin
                q_next   = RST_BCD;
                err_next = 1'b1;
            end
        end
        else if (en) begin
            if (up_dn) begin
                if (at_max) begin
`ifdef BCD_CNT_SAT_EN
                    q_next = q;
`else
                    q_next    = '0;
                    wrap_next = 1'b1;
`endif
                end
                else begin
                    q_next = inc_val;
                end
            end
            else begin
                if (at_zero) begin
`ifdef BCD_CNT_SAT_EN
                    q_next = q;
`else
                    q_next    = MAX_BCD;
                    wrap_next = 1'b1;
`endif
                end
                else begin
                    q_next = dec_val;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q    <= RST_BCD;
            wrap <= 1'b0;
            err  <= 1'b0;
        end
        else begin
            q    <= q_next;
            wrap <= wrap_next;
            err  <= err_next;
        end
    end

    assign tc = en & ((up_dn & at_max) | (~up_dn & at_zero));

endmodule

// File: tb/tb_bcd_updown_counter.sv
module tb_bcd_updown_counter;

`ifdef BCD_CNT_SAT_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    logic       clk;
    logic       rst_n;
    logic       en;
    logic       up_dn;
    logic       load;
    logic [7:0] load_val;
    logic [7:0] q;
    logic       tc;
    logic       wrap;
    logic       err;

    logic       en1;
    logic       up_dn1;
    logic       load1;
    logic [3:0] load_val1;
    logic [3:0] q1;
    logic       tc1;
    logic       wrap1;
    logic       err1;

    int total;
    int bad;

    bcd_updown_counter #(.DIGITS(2), .MAX_VAL(59), .RST_VAL(0)) dut (
        .clk(clk), .rst_n(rst_n), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .q(q), .tc(tc), .wrap(wrap), .err(err)
    );

    bcd_updown_counter #(.DIGITS(1), .MAX_VAL(8), .RST_VAL(0)) dut1 (
        .clk(clk), .rst_n(rst_n), .en(en1), .up_dn(up_dn1), .load(load1),
        .load_val(load_val1), .q(q1), .tc(tc1), .wrap(wrap1), .err(err1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       en;
        logic       up_dn;
        logic       load;
        logic [7:0] lv;
        logic       tc;      // tc with these inputs, before the edge
        logic [7:0] q;       // after the edge
        logic       wrap;
        logic       err;
    } vec_t;

    vec_t vecs[18];

    function automatic logic [7:0] bcd2(input int v);
        return {4'(v / 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one edge; returns 2 time units after it so outputs are settled
    // and new inputs land well before the next edge.
    task automatic cyc();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00;
        en1 = 1'b0; up_dn1 = 1'b1; load1 = 1'b0; load_val1 = 4'h0;
        cyc();
        rst_n = 1'b1;
    endtask

    initial begin
        int e;
        int wraps;
        logic expw;

        total = 0;
        bad   = 0;

        //                en    up    load  lv     tc    q      wrap  err
        vecs[0]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b1, 8'h37, 1'b0, 8'h37, 1'b0, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h3A, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b1, 1'b1, 8'h75, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 1'b1, 8'h59, 1'b0, 8'h59, 1'b0, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h58, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 8'h50, 1'b0, 8'h50, 1'b0, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h49, 1'b0, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h50, 1'b0, 1'b0};
        vecs[10] = '{1'b0, 1'b1, 1'b1, 8'h09, 1'b0, 8'h09, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h10, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 8'h09, 1'b0, 1'b0};
        vecs[13] = '{1'b0, 1'b1, 1'b1, 8'h60, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[14] = '{1'b1, 1'b1, 1'b1, 8'h59, 1'b0, 8'h59, 1'b0, 1'b0};
        vecs[15] = '{1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h59, 1'b0, 1'b0};
        vecs[16] = '{1'b0, 1'b1, 1'b1, 8'hA0, 1'b0, 8'h00, 1'b0, 1'b1};
        vecs[17] = '{1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 8'h01, 1'b0, 1'b0};

        // Reset state, observed before any clock edge.
        rst_n = 1'b0;
        en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = 8'h00;
        en1 = 1'b0; up_dn1 = 1'b1; load1 = 1'b0; load_val1 = 4'h0;
        #2;
        chk("rst_q", 32'(q), 32'h00);
        chk("rst_wrap", 32'(wrap), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_tc", 32'(tc), 32'h0);
        chk("rst_q1", 32'(q1), 32'h0);
        cyc();
        rst_n = 1'b1;

        // Directed vector table.
        for (int i = 0; i < 18; i++) begin
            en = vecs[i].en; up_dn = vecs[i].up_dn;
            load = vecs[i].load; load_val = vecs[i].lv;
            #1;
            chk($sformatf("vec%0d_tc", i), 32'(tc), 32'(vecs[i].tc));
            cyc();
            chk($sformatf("vec%0d_q", i), 32'(q), 32'(vecs[i].q));
            chk($sformatf("vec%0d_wrap", i), 32'(wrap), 32'(vecs[i].wrap));
            chk($sformatf("vec%0d_err", i), 32'(err), 32'(vecs[i].err));
        end

        // Full up-count sweep over one modulus (plus one edge).
        do_reset();
        en = 1'b1; up_dn = 1'b1;
        e = 0;
        for (int i = 0; i < 61; i++) begin
            #1;
            chk($sformatf("up%0d_tc", i), 32'(tc), 32'(e == 59));
            cyc();
            expw = 1'b0;
            if (e == 59) begin
                if (!SAT) begin
                    e = 0;
                    expw = 1'b1;
                end
            end
            else begin
                e = e + 1;
            end
            chk($sformatf("up%0d_q", i), 32'(q), 32'(bcd2(e)));
            chk($sformatf("up%0d_wrap", i), 32'(wrap), 32'(expw));
        end

        // Down from zero: wrap to MAX (or hold when saturating), then step.
        do_reset();
        en = 1'b1; up_dn = 1'b0;
        #1;
        chk("dn_tc0", 32'(tc), 32'h1);
        cyc();
        chk("dn_q0", 32'(q), SAT ? 32'h00 : 32'h59);
        chk("dn_wrap0", 32'(wrap), SAT ? 32'h0 : 32'h1);
        cyc();
        chk("dn_q1", 32'(q), SAT ? 32'h00 : 32'h58);
        chk("dn_wrap1", 32'(wrap), 32'h0);

        // Up/down direction switched mid-run takes effect on the same edge.
        up_dn = 1'b1;
        cyc();
        chk("dir_q", 32'(q), SAT ? 32'h01 : 32'h59);

        // Asynchronous reset between edges, then resume.
        do_reset();
        en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 23; i++) cyc();
        chk("mid_pre_q", 32'(q), 32'h23);
        rst_n = 1'b0;
        #1;
        chk("mid_async_q", 32'(q), 32'h00);
        #1;
        rst_n = 1'b1;
        cyc();
        chk("mid_resume_q", 32'(q), 32'h01);

        // Single-digit mod-9 counter.
        do_reset();
        en = 1'b0;
        en1 = 1'b1; up_dn1 = 1'b1;
        e = 0;
        wraps = 0;
        for (int i = 0; i < 18; i++) begin
            cyc();
            if (e == 8) begin
                if (!SAT) e = 0;
            end
            else begin
                e = e + 1;
            end
            chk($sformatf("d1_%0d_q", i), 32'(q1), 32'(e));
            if (wrap1) wraps++;
        end
        cyc();
        if (wrap1) wraps++;
        chk("d1_wraps", 32'(wraps), SAT ? 32'd0 : 32'd2);
        en1 = 1'b0;

`ifdef BCD_CNT_SAT_EN
        // Saturation holds at the upper boundary with tc still asserted.
        load = 1'b1; load_val = 8'h59;
        cyc();
        load = 1'b0; en = 1'b1; up_dn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("sat%0d_tc", i), 32'(tc), 32'h1);
            cyc();
            chk($sformatf("sat%0d_q", i), 32'(q), 32'h59);
            chk($sformatf("sat%0d_wrap", i), 32'(wrap), 32'h0);
        end
        load = 1'b1; load_val = 8'h00;
        cyc();
        load = 1'b0; up_dn = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk($sformatf("satdn%0d_q", i), 32'(q), 32'h00);
            chk($sformatf("satdn%0d_wrap", i), 32'(wrap), 32'h0);
        end
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
